booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one 8-bit sequential Booth multiplier among `N_REQ` requesters. It accepts per-requester signed operand pairs, grants one requester at a time and drives the multiplier's load handshake. It waits the fixed multiplier latency, captures the 16-bit signed product and returns it to the granted requester with a one-cycle done pulse. It sits between the requesting datapath units and a single multiplier instance, which remains a separate module in the same top level.

## Interface
- `N_REQ`, 4: number of requesters; must be at least 2.
- `W`, 8: operand width; the product is `2*W` bits.
- `MUL_LATENCY`, 8: clock edges from the multiplier sampling `mul_load` to a valid `mul_prod`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  per-requester request level.
- `op1_in`  in  N_REQ*W  packed multiplicands; requester i uses slice [i*W +: W].
- `op2_in`  in  N_REQ*W  packed multipliers, same packing as `op1_in`.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: operands of that requester have been captured.
- `done`  out  N_REQ  one-hot, one-cycle pulse: `prod_out` is valid for that requester.
- `prod_out`  out  2*W  signed product; holds its value until the next done.
- `busy`  out  1  high whenever the state is not IDLE.
- `mul_op1`, `mul_op2`  out  W  latched operands driven to the multiplier.
- `mul_load`  out  1  multiplier load strobe.
- `mul_prod`  in  2*W  multiplier product.

## Operation
- FSM has four states: IDLE, LOAD, WAIT, DONE.
  - IDLE: if any `req` bit is set, pick the winner by round-robin, latch its operands into `mul_op1`/`mul_op2`, record its index, pulse `gnt[idx]`, and go to LOAD. With no request, stay in IDLE.
  - LOAD: drive `mul_load`=1 for exactly one cycle, clear the counter, go to WAIT.
  - WAIT: increment the counter each edge. Go to DONE when counter == `MUL_LATENCY`-1.
  - DONE: register `mul_prod` into `prod_out`, pulse `done[idx]`, advance the pointer, go to IDLE.
- Round-robin rule: search starts at index `ptr`. After granting index i, `ptr` becomes (i+1) mod `N_REQ`; the pointer wraps. After reset `ptr`=0.
- Requests are sampled only in IDLE. Requests raised during busy are held off until IDLE; the requester keeps `req` high until it sees `gnt`.
- `req` still high after the requester's own `done` counts as a new request. It competes at the lowest priority because the pointer has moved past it.
- Operands are captured once in IDLE. Changes on `op*_in` after `gnt` have no effect.
- No arithmetic inside the arbiter; the product passes through unmodified with its signed 2's-complement width.

## Timing
- Reset (asynchronous, `rst`=0) forces:
  - state IDLE, `ptr`=0;
  - `gnt`, `done`, `mul_load`, `busy` = 0;
  - `prod_out`, `mul_op1`, `mul_op2` = 0.
- Reset mid-operation abandons the multiplication; no `done` is issued.
- With `req` sampled at edge E:
  - `gnt` and `mul_load` are high during (E, E+1];
  - `done` is high during (E+`MUL_LATENCY`+2, E+`MUL_LATENCY`+3], i.e. E+10 with defaults.
- The next request can be sampled no earlier than edge E+`MUL_LATENCY`+3. Throughput is one product per `MUL_LATENCY`+3 cycles.
- All outputs are registered; there are no combinational paths from `req` to `gnt`.

## Structure
- Package `booth_arb_pkg` holds:
  - the state enum (IDLE, LOAD, WAIT, DONE);
  - default constants for `W`, `N_REQ` and `MUL_LATENCY`;
  - the counter width as clog2 of `MUL_LATENCY`.
- Sub-module `rr_picker`: combinational, taking `req` and `ptr` and returning a one-hot winner plus its index. It is reused by other shared-resource arbiters.
- The multiplier is not instantiated inside this block.

## Test plan
- Single request: requester 0 sends 82 × 29 (0x52, 0x1D) → `gnt[0]` at E+1, `done[0]` at E+10, `prod_out`=2378.
- Sign cases, issued sequentially by requesters 1–3:
  - 113 × −78 → −8814;
  - −48 × 10 → −480;
  - −105 × −126 → 13230.
- Each case gives the correct `done` index and `prod_out`.
- Contention: all four `req` held high from reset → grants in order 0,1,2,3,0, eleven cycles apart. `busy` never drops between jobs while requests remain.
- Reset during WAIT (e.g. 4 cycles after `gnt`) → all outputs 0 immediately and no `done` pulse. The next request is granted to index 0 when it wins.
- Operand change after `gnt`: change `op1_in` of the granted requester to 0 → `prod_out` still equals the product of the latched values.

Source files
------------

// File: rtl/booth_arb_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
// The counter width is derived from the latency so the terminal compare always fits.
package booth_arb_pkg;

    localparam int W_DEF           = 8;
    localparam int N_REQ_DEF       = 4;
    localparam int MUL_LATENCY_DEF = 8;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(MUL_LATENCY_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr wins.
// Returns the winner both one-hot and as an index, plus a valid flag.
module rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_idx,
    output logic          any
);

    always_comb begin
        int pos;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        pos     = 0;
        // Walk from farthest to nearest so the candidate closest to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % N;
            if (req[pos]) begin
                any     = 1'b1;
                win_idx = IW'(pos);
            end
        end
        if (any) begin
            win[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin sequencer sharing one external sequential Booth multiplier among N_REQ requesters.
//   state | meaning
//   IDLE  | sample requests, latch winner operands, pulse gnt
//   LOAD  | mul_load high for one cycle, clear latency counter
//   WAIT  | count multiplier latency
//   DONE  | capture product, pulse done, advance round-robin pointer
module booth_mult_arbiter
    import booth_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int W           = W_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] op1_in,
    input  logic [N_REQ*W-1:0] op2_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [2*W-1:0]     prod_out,
    output logic               busy,
    output logic [W-1:0]       mul_op1,
    output logic [W-1:0]       mul_op2,
    output logic               mul_load,
    input  logic [2*W-1:0]     mul_prod
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(MUL_LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_LATENCY - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [N_REQ-1:0] gnt_nxt, done_nxt;
    logic [2*W-1:0]   prod_nxt;
    logic [W-1:0]     op1_nxt, op2_nxt;
    logic             load_nxt, busy_nxt;

    logic [N_REQ-1:0] pick_win;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    rr_picker #(.N(N_REQ)) u_picker (
        .req     (req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            idx      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            done     <= '0;
            prod_out <= '0;
            busy     <= 1'b0;
            mul_op1  <= '0;
            mul_op2  <= '0;
            mul_load <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            idx      <= idx_nxt;
            cnt      <= cnt_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            prod_out <= prod_nxt;
            busy     <= busy_nxt;
            mul_op1  <= op1_nxt;
            mul_op2  <= op2_nxt;
            mul_load <= load_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        gnt_nxt   = '0;
        done_nxt  = '0;
        prod_nxt  = prod_out;
        busy_nxt  = busy;
        op1_nxt   = mul_op1;
        op2_nxt   = mul_op2;
        load_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    op1_nxt   = op1_in[int'(pick_idx)*W +: W];
                    op2_nxt   = op2_in[int'(pick_idx)*W +: W];
                    idx_nxt   = pick_idx;
                    gnt_nxt   = pick_win;
                    load_nxt  = 1'b1;
                    busy_nxt  = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    busy_nxt  = 1'b0;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE: begin
                prod_nxt      = mul_prod;
                done_nxt[idx] = 1'b1;
                ptr_nxt       = (idx == IDX_LAST) ? '0 : idx + IW'(1);
                // Keep busy through the one IDLE cycle when another job is already waiting.
                busy_nxt      = |req;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Self-checking bench for booth_mult_arbiter with a behavioural multiplier and round-robin model.
module tb_booth_mult_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op1_in, op2_in;
    logic [N-1:0]     gnt, done;
    logic [2*W-1:0]   prod_out;
    logic             busy;
    logic [W-1:0]     mul_op1, mul_op2;
    logic             mul_load;
    logic [2*W-1:0]   mul_prod;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    int cyc      = 0;

    booth_mult_arbiter #(.N_REQ(N), .W(W), .MUL_LATENCY(LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op1_in   (op1_in),
        .op2_in   (op2_in),
        .gnt      (gnt),
        .done     (done),
        .prod_out (prod_out),
        .busy     (busy),
        .mul_op1  (mul_op1),
        .mul_op2  (mul_op2),
        .mul_load (mul_load),
        .mul_prod (mul_prod)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sval(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    function automatic int rr_model(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Multiplier stand-in: product appears LAT edges after mul_load is sampled, garbage before.
    int mcnt = 0;
    logic [15:0] mres = '0;
    initial mul_prod = '0;
    always @(posedge clk) begin
        if (mul_load) begin
            mres     <= 16'(sval(mul_op1) * sval(mul_op2));
            mul_prod <= ~16'(sval(mul_op1) * sval(mul_op2));
            mcnt     <= LAT;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) mul_prod <= mres;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ptr_m = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; op1_in = '0; op2_in = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (gnt !== '0)      begin n_fail++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        n_checks++; if (done !== '0)     begin n_fail++; $display("FAIL reset_done: got %b expected 0000", done); end
        n_checks++; if (mul_load !== 0)  begin n_fail++; $display("FAIL reset_load: got %b expected 0", mul_load); end
        n_checks++; if (busy !== 0)      begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (prod_out !== '0) begin n_fail++; $display("FAIL reset_prod: got %h expected 0000", prod_out); end
        n_checks++; if (mul_op1 !== '0 || mul_op2 !== '0)
            begin n_fail++; $display("FAIL reset_ops: got %h/%h expected 00/00", mul_op1, mul_op2); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 0 || gnt !== '0)
            begin n_fail++; $display("FAIL idle_quiet: got busy=%b gnt=%b expected 0/0000", busy, gnt); end
        ptr_m = 0;
    endtask

    task automatic test_single();
        op1_in[0 +: 8] = 8'h52; op2_in[0 +: 8] = 8'h1D;
        req = 4'b0001;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
        n_checks++; if (mul_load !== 1)  begin n_fail++; $display("FAIL single_load: got %b expected 1", mul_load); end
        n_checks++; if (mul_op1 !== 8'h52 || mul_op2 !== 8'h1D)
            begin n_fail++; $display("FAIL single_ops: got %h/%h expected 52/1d", mul_op1, mul_op2); end
        req = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_checks++; if (gnt !== '0 || mul_load !== 0)
                    begin n_fail++; $display("FAIL single_pulse: got gnt=%b load=%b expected 0000/0", gnt, mul_load); end
            end
            if (k < 10) begin
                n_checks++; if (done !== '0) begin n_fail++; $display("FAIL single_early k=%0d: got %b expected 0000", k, done); end
            end else begin
                n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b expected 0001", done); end
                n_checks++; if (int'($signed(prod_out)) !== 2378)
                    begin n_fail++; $display("FAIL single_prod: got %0d expected 2378", $signed(prod_out)); end
            end
        end
        ptr_m = 1;
    endtask

    task automatic test_sign();
        logic [7:0] a [3] = '{8'h71, 8'hD0, 8'h97};
        logic [7:0] b [3] = '{8'hB2, 8'h0A, 8'h82};
        int         e [3] = '{-8814, -480, 13230};
        for (int c = 0; c < 3; c++) begin
            int i;
            logic [3:0] oh;
            i  = c + 1;
            oh = 4'b0001 << i;
            op1_in[i*8 +: 8] = a[c]; op2_in[i*8 +: 8] = b[c];
            req = oh;
            @(negedge clk);
            n_checks++; if (gnt !== oh) begin n_fail++; $display("FAIL sign_gnt c=%0d: got %b expected %b", c, gnt, oh); end
            req = '0;
            repeat (10) @(negedge clk);
            n_checks++; if (done !== oh) begin n_fail++; $display("FAIL sign_done c=%0d: got %b expected %b", c, done, oh); end
            n_checks++; if (int'($signed(prod_out)) !== e[c])
                begin n_fail++; $display("FAIL sign_prod c=%0d: got %0d expected %0d", c, $signed(prod_out), e[c]); end
            ptr_m = (i + 1) % N;
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [7:0] a [N];
        logic [7:0] b [N];
        int last;
        do_reset();
        for (int i = 0; i < N; i++) begin
            a[i] = 8'($urandom); b[i] = 8'($urandom);
            op1_in[i*8 +: 8] = a[i]; op2_in[i*8 +: 8] = b[i];
        end
        req = 4'b1111;
        @(negedge clk);
        last = cyc;
        for (int j = 0; j < 5; j++) begin
            logic [3:0] oh;
            oh = 4'b0001 << order[j];
            n_checks++; if (gnt !== oh) begin n_fail++; $display("FAIL cont_gnt j=%0d: got %b expected %b", j, gnt, oh); end
            if (j > 0) begin
                n_checks++; if (cyc - last !== 11)
                    begin n_fail++; $display("FAIL cont_spacing j=%0d: got %0d expected 11", j, cyc - last); end
            end
            last = cyc;
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                n_checks++; if (busy !== 1) begin n_fail++; $display("FAIL cont_busy j=%0d k=%0d: got %b expected 1", j, k, busy); end
            end
            n_checks++; if (done !== oh) begin n_fail++; $display("FAIL cont_done j=%0d: got %b expected %b", j, done, oh); end
            n_checks++; if (int'($signed(prod_out)) !== sval(a[order[j]]) * sval(b[order[j]]))
                begin n_fail++; $display("FAIL cont_prod j=%0d: got %0d expected %0d", j, $signed(prod_out),
                                         sval(a[order[j]]) * sval(b[order[j]])); end
            ptr_m = (order[j] + 1) % N;
            if (j == 4) req = '0;
            @(negedge clk);
        end
        n_checks++; if (busy !== 0 || gnt !== '0)
            begin n_fail++; $display("FAIL cont_drain: got busy=%b gnt=%b expected 0/0000", busy, gnt); end
    endtask

    task automatic test_reset_wait();
        bit seen;
        do_reset();
        op1_in = {4{8'h11}}; op2_in = {4{8'h03}};
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (11) @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL rw_gnt: got %b expected 0010", gnt); end
        req = '0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (gnt !== '0 || done !== '0 || mul_load !== 0 || busy !== 0 ||
                        prod_out !== '0 || mul_op1 !== '0 || mul_op2 !== '0)
            begin n_fail++; $display("FAIL rw_clear: got gnt=%b done=%b load=%b busy=%b prod=%h ops=%h/%h expected all 0",
                                     gnt, done, mul_load, busy, prod_out, mul_op1, mul_op2); end
        @(negedge clk);
        rst = 1'b1;
        ptr_m = 0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done !== '0) seen = 1;
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL rw_no_done: got done pulse expected none"); end
        op1_in[0 +: 8] = 8'h07; op2_in[0 +: 8] = 8'hFD;
        req = 4'b1001;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL rw_regrant: got %b expected 0001", gnt); end
        req = '0;
        repeat (10) @(negedge clk);
        n_checks++; if (done !== 4'b0001 || int'($signed(prod_out)) !== -21)
            begin n_fail++; $display("FAIL rw_done: got %b/%0d expected 0001/-21", done, $signed(prod_out)); end
        ptr_m = 1;
    endtask

    task automatic test_opchange();
        logic [7:0] a, b;
        a = 8'($urandom_range(1, 255)); b = 8'($urandom_range(1, 255));
        op1_in[8 +: 8] = a; op2_in[8 +: 8] = b;
        req = 4'b0010;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL opc_gnt: got %b expected 0010", gnt); end
        req = '0;
        op1_in[8 +: 8] = 8'h00;
        op2_in[8 +: 8] = ~b;
        repeat (10) @(negedge clk);
        n_checks++; if (done !== 4'b0010 || int'($signed(prod_out)) !== sval(a) * sval(b))
            begin n_fail++; $display("FAIL opc_prod: got %b/%0d expected 0010/%0d", done, $signed(prod_out), sval(a) * sval(b)); end
        ptr_m = 2;
    endtask

    task automatic test_random();
        logic [7:0] a [N];
        logic [7:0] b [N];
        for (int it = 0; it < 20; it++) begin
            logic [N-1:0] mask;
            logic [3:0]   oh;
            int           w;
            mask = N'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                a[i] = 8'($urandom); b[i] = 8'($urandom);
                op1_in[i*8 +: 8] = a[i]; op2_in[i*8 +: 8] = b[i];
            end
            w  = rr_model(mask, ptr_m);
            oh = 4'b0001 << w;
            req = mask;
            @(negedge clk);
            n_checks++; if (gnt !== oh) begin n_fail++; $display("FAIL rnd_gnt it=%0d: got %b expected %b", it, gnt, oh); end
            n_checks++; if (mul_op1 !== a[w] || mul_op2 !== b[w])
                begin n_fail++; $display("FAIL rnd_ops it=%0d: got %h/%h expected %h/%h", it, mul_op1, mul_op2, a[w], b[w]); end
            req = '0;
            repeat (10) @(negedge clk);
            n_checks++; if (done !== oh || int'($signed(prod_out)) !== sval(a[w]) * sval(b[w]))
                begin n_fail++; $display("FAIL rnd_done it=%0d: got %b/%0d expected %b/%0d", it, done, $signed(prod_out),
                                         oh, sval(a[w]) * sval(b[w])); end
            ptr_m = (w + 1) % N;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign();
        test_contention();
        test_reset_wait();
        test_opchange();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
